// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, timing helper and command constants.
package ps2_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_REL, S_DONE, S_ERR
  } ps2_tx_state_t;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam logic [7:0] PS2_ACK = 8'hFA;
  function automatic int us_to_cyc(input int clk_hz, input int us);
    return clk_hz / 1_000_000 * us;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchroniser with falling-edge detect for one PS/2 line.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic lvl_o,
  output logic fe_o
);
  // [0] metastable stage, [1] synced level, [2] previous synced level; idle line is high
  logic [2:0] sh_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sh_q <= '1;
    else sh_q <= {sh_q[1:0], line_i};
  assign lvl_o = sh_q[1];
  assign fe_o = sh_q[2] & ~sh_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving both lines open-drain.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int INH_CYC = us_to_cyc(CLK_HZ, INHIBIT_US);
  localparam int SETUP_CYC = us_to_cyc(CLK_HZ, 1);
  localparam int TO_CYC = us_to_cyc(CLK_HZ, TIMEOUT_US);
  localparam int CMAX = (TO_CYC > INH_CYC) ? TO_CYC : INH_CYC;
  localparam int CW = $clog2(CMAX + 1);
  ps2_tx_state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0] sh_q, sh_d;
  logic [3:0] bit_q, bit_d;
  logic dat_oe_q, dat_oe_d;
  logic clk_lvl, clk_fe, dat_lvl, dat_fe_unused, to;
  ps2_line_sync u_clk_sync (.clk(clk), .rst(reset), .line_i(ps2clk), .lvl_o(clk_lvl), .fe_o(clk_fe));
  ps2_line_sync u_dat_sync (.clk(clk), .rst(reset), .line_i(ps2dat), .lvl_o(dat_lvl), .fe_o(dat_fe_unused));
  assign tx_ready = st_q == S_IDLE;
  assign busy = ~tx_ready;
  assign ps2clk_oe = st_q == S_INHIBIT || st_q == S_REQ;
  assign ps2dat_oe = dat_oe_q & (st_q == S_REQ || st_q == S_SHIFT);
  assign done = st_q == S_DONE;
  assign error = st_q == S_ERR;
  // a device edge always wins over a timeout landing in the same cycle
  assign to = cnt_q == CW'(TO_CYC - 1) && !clk_fe;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    sh_d = sh_q;
    bit_d = bit_q;
    dat_oe_d = dat_oe_q;
    case (st_q)
      S_IDLE: begin
        cnt_d = '0;
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          st_d = S_INHIBIT;
          sh_d = {1'b1, ~^tx_data, tx_data};
          bit_d = '0;
        end
      end
      S_INHIBIT: if (cnt_q == CW'(INH_CYC - 1)) begin
        st_d = S_REQ;
        cnt_d = '0;
        dat_oe_d = 1'b1;
      end
      S_REQ: if (cnt_q == CW'(SETUP_CYC - 1)) begin
        st_d = S_SHIFT;
        cnt_d = '0;
      end
      S_SHIFT: begin
        if (clk_fe) begin
          cnt_d = '0;
          dat_oe_d = ~sh_q[0];
          sh_d = sh_q >> 1;
          bit_d = bit_q + 4'd1;
          st_d = bit_q == 4'd9 ? S_ACK : S_SHIFT;
        end else if (to) st_d = S_ERR;
      end
      S_ACK: begin
        if (clk_fe) begin
          cnt_d = '0;
          st_d = dat_lvl ? S_ERR : S_WAIT_REL;
        end else if (to) st_d = S_ERR;
      end
      S_WAIT_REL: begin
        if (clk_fe) cnt_d = '0;
        if (clk_lvl && dat_lvl) st_d = S_DONE;
        else if (to) st_d = S_ERR;
      end
      default: begin
        st_d = S_IDLE;
        cnt_d = '0;
        dat_oe_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= S_IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      bit_q <= '0;
      dat_oe_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      dat_oe_q <= dat_oe_d;
    end
endmodule
